// File: rtl/lc3b_mem_arbiter.sv
// Two-port (ifetch + data) to single physical memory port arbiter for the lc3b core.
// Holds one captured request at a time; the response is routed back to the granted requester.
module lc3b_mem_arbiter #(
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ifetch_read,
  input  logic [15:0] ifetch_address,
  output logic [15:0] ifetch_rdata,
  output logic        ifetch_resp,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  input  logic [1:0]  mem_byte_enable,
  output logic [15:0] mem_rdata,
  output logic        mem_resp,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [15:0] pmem_address,
  output logic [15:0] pmem_wdata,
  output logic [1:0]  pmem_byte_enable,
  input  logic [15:0] pmem_rdata,
  input  logic        pmem_resp,
  output logic [1:0]  dbg_state
);

  // Handshake: a requester holds its request until its resp pulse; pmem strobes are
  // held until pmem_resp, and resp is forwarded combinationally in that same cycle.
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANT_IF   = 2'd1,
    GRANT_DATA = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        grant_if, grant_data;
  logic        if_req, d_req;
  logic        alt_pending_q, alt_to_data_q;
  logic [15:0] cap_addr_q, cap_wdata_q;
  logic [1:0]  cap_be_q;
  logic        cap_write_q;

  assign if_req    = ifetch_read;
  assign d_req     = mem_read | mem_write;
  assign dbg_state = state_q;

  always_comb begin
    state_d    = state_q;
    grant_if   = 1'b0;
    grant_data = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_req && d_req) begin
          // Under contention the port owed a turn wins; otherwise the static priority.
          if (alt_pending_q) begin
            grant_data = alt_to_data_q;
            grant_if   = ~alt_to_data_q;
          end else begin
            grant_data = DATA_FIRST;
            grant_if   = ~DATA_FIRST;
          end
        end else begin
          grant_if   = if_req;
          grant_data = d_req;
        end
        if (grant_if)   state_d = GRANT_IF;
        if (grant_data) state_d = GRANT_DATA;
      end
      GRANT_IF, GRANT_DATA: begin
        if (pmem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      alt_pending_q <= 1'b0;
      alt_to_data_q <= 1'b0;
      cap_addr_q    <= 16'h0000;
      cap_wdata_q   <= 16'h0000;
      cap_be_q      <= 2'b00;
      cap_write_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant_if) begin
        cap_addr_q  <= ifetch_address;
        cap_wdata_q <= 16'h0000;
        cap_be_q    <= 2'b11;
        cap_write_q <= 1'b0;
      end
      if (grant_data) begin
        cap_addr_q  <= mem_address;
        cap_wdata_q <= mem_wdata;
        cap_be_q    <= mem_byte_enable;
        cap_write_q <= mem_write;
      end
      // A new contention re-arms the owed turn; granting the owed port settles it.
      if (grant_if && d_req) begin
        alt_pending_q <= 1'b1;
        alt_to_data_q <= 1'b1;
      end else if (grant_data && if_req) begin
        alt_pending_q <= 1'b1;
        alt_to_data_q <= 1'b0;
      end else if (alt_pending_q && (grant_if || grant_data) &&
                   (grant_data == alt_to_data_q)) begin
        alt_pending_q <= 1'b0;
      end
    end
  end

  assign pmem_read        = (state_q == GRANT_IF) || ((state_q == GRANT_DATA) && !cap_write_q);
  assign pmem_write       = (state_q == GRANT_DATA) && cap_write_q;
  assign pmem_address     = cap_addr_q;
  assign pmem_wdata       = cap_wdata_q;
  assign pmem_byte_enable = cap_be_q;

  assign ifetch_resp  = (state_q == GRANT_IF) && pmem_resp;
  assign ifetch_rdata = (state_q == GRANT_IF) ? pmem_rdata : 16'h0000;
  assign mem_resp     = (state_q == GRANT_DATA) && pmem_resp;
  assign mem_rdata    = (state_q == GRANT_DATA) ? pmem_rdata : 16'h0000;

endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// Directed bench for lc3b_mem_arbiter: inputs driven 1ns after rising edge,
// outputs checked on the falling edge against hand-computed values.
module tb_lc3b_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ifetch_read;
  logic [15:0] ifetch_address;
  logic [15:0] ifetch_rdata;
  logic        ifetch_resp;
  logic        mem_read, mem_write;
  logic [15:0] mem_address, mem_wdata;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_rdata;
  logic        mem_resp;
  logic        pmem_read, pmem_write;
  logic [15:0] pmem_address, pmem_wdata;
  logic [1:0]  pmem_byte_enable;
  logic [15:0] pmem_rdata;
  logic        pmem_resp;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [15:0] S_IDLE = 16'd0, S_IF = 16'd1, S_DATA = 16'd2;

  lc3b_mem_arbiter #(.DATA_FIRST(1'b1)) dut (
    .clk(clk), .reset_n(reset_n),
    .ifetch_read(ifetch_read), .ifetch_address(ifetch_address),
    .ifetch_rdata(ifetch_rdata), .ifetch_resp(ifetch_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_byte_enable(pmem_byte_enable),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    ifetch_read = 1'b0; ifetch_address = 16'h0;
    mem_read = 1'b0; mem_write = 1'b0; mem_address = 16'h0;
    mem_wdata = 16'h0; mem_byte_enable = 2'b00;
    pmem_rdata = 16'h0; pmem_resp = 1'b0;
    repeat (2) cyc();
    settle();
    check("rst_state", {14'd0, dbg_state}, S_IDLE);
    check("rst_pread", {15'd0, pmem_read}, 16'd0);
    check("rst_pwrite", {15'd0, pmem_write}, 16'd0);
    check("rst_paddr", pmem_address, 16'h0000);
    check("rst_if_resp", {15'd0, ifetch_resp}, 16'd0);
    check("rst_mem_resp", {15'd0, mem_resp}, 16'd0);
    cyc(); reset_n = 1'b1;

    // lone fetch, address change mid-grant, resp after 3 strobe cycles
    cyc(); ifetch_read = 1'b1; ifetch_address = 16'h0040;
    settle();
    check("if_no_strobe_yet", {15'd0, pmem_read}, 16'd0);
    cyc(); settle();
    check("if_pread", {15'd0, pmem_read}, 16'd1);
    check("if_paddr", pmem_address, 16'h0040);
    check("if_pbe", {14'd0, pmem_byte_enable}, 16'd3);
    check("if_pwrite", {15'd0, pmem_write}, 16'd0);
    cyc(); ifetch_address = 16'h0100;
    settle();
    check("if_addr_held", pmem_address, 16'h0040);
    cyc(); pmem_resp = 1'b1; pmem_rdata = 16'h1234;
    settle();
    check("if_resp", {15'd0, ifetch_resp}, 16'd1);
    check("if_rdata", ifetch_rdata, 16'h1234);
    check("if_mem_resp", {15'd0, mem_resp}, 16'd0);
    check("if_mem_rdata", mem_rdata, 16'h0000);
    cyc(); pmem_resp = 1'b0; ifetch_read = 1'b0;
    settle();
    check("if_back_idle", {14'd0, dbg_state}, S_IDLE);
    check("if_pread_off", {15'd0, pmem_read}, 16'd0);

    // stray pmem_resp in IDLE
    cyc(); pmem_resp = 1'b1;
    settle();
    check("idle_if_resp", {15'd0, ifetch_resp}, 16'd0);
    check("idle_mem_resp", {15'd0, mem_resp}, 16'd0);
    check("idle_stays", {14'd0, dbg_state}, S_IDLE);
    cyc(); pmem_resp = 1'b0;

    // data write with partial byte mask
    cyc(); mem_write = 1'b1; mem_address = 16'h2000; mem_wdata = 16'hBEEF; mem_byte_enable = 2'b10;
    cyc(); settle();
    check("wr_pwrite", {15'd0, pmem_write}, 16'd1);
    check("wr_pread", {15'd0, pmem_read}, 16'd0);
    check("wr_paddr", pmem_address, 16'h2000);
    check("wr_pwdata", pmem_wdata, 16'hBEEF);
    check("wr_pbe", {14'd0, pmem_byte_enable}, 16'd2);
    cyc(); pmem_resp = 1'b1;
    settle();
    check("wr_mem_resp", {15'd0, mem_resp}, 16'd1);
    check("wr_if_resp", {15'd0, ifetch_resp}, 16'd0);
    cyc(); pmem_resp = 1'b0; mem_write = 1'b0;

    // read and write both high -> write
    cyc(); mem_read = 1'b1; mem_write = 1'b1; mem_address = 16'h3000;
    mem_wdata = 16'h5555; mem_byte_enable = 2'b01;
    cyc(); settle();
    check("rw_pwrite", {15'd0, pmem_write}, 16'd1);
    check("rw_pread", {15'd0, pmem_read}, 16'd0);
    check("rw_pbe", {14'd0, pmem_byte_enable}, 16'd1);
    cyc(); pmem_resp = 1'b1; pmem_rdata = 16'hABCD;
    settle();
    check("rw_mem_resp", {15'd0, mem_resp}, 16'd1);
    cyc(); pmem_resp = 1'b0; mem_read = 1'b0; mem_write = 1'b0;

    // contention: data first, then fetch despite data re-request, then data again
    cyc(); ifetch_read = 1'b1; ifetch_address = 16'h0200;
    mem_read = 1'b1; mem_address = 16'h4000;
    cyc(); settle();
    check("ct_state_data", {14'd0, dbg_state}, S_DATA);
    check("ct_paddr_data", pmem_address, 16'h4000);
    check("ct_pread_data", {15'd0, pmem_read}, 16'd1);
    cyc(); pmem_resp = 1'b1; pmem_rdata = 16'h1111;
    settle();
    check("ct_mem_resp", {15'd0, mem_resp}, 16'd1);
    check("ct_mem_rdata", mem_rdata, 16'h1111);
    check("ct_if_resp0", {15'd0, ifetch_resp}, 16'd0);
    check("ct_if_rdata0", ifetch_rdata, 16'h0000);
    cyc(); pmem_resp = 1'b0; mem_address = 16'h4002;
    settle();
    check("ct_turnaround_idle", {14'd0, dbg_state}, S_IDLE);
    cyc(); settle();
    check("ct_state_if", {14'd0, dbg_state}, S_IF);
    check("ct_paddr_if", pmem_address, 16'h0200);
    cyc(); pmem_resp = 1'b1; pmem_rdata = 16'h2222;
    settle();
    check("ct_if_resp", {15'd0, ifetch_resp}, 16'd1);
    check("ct_if_rdata", ifetch_rdata, 16'h2222);
    check("ct_mem_resp0", {15'd0, mem_resp}, 16'd0);
    cyc(); pmem_resp = 1'b0; ifetch_read = 1'b0;
    cyc(); settle();
    check("ct_state_data2", {14'd0, dbg_state}, S_DATA);
    check("ct_paddr_data2", pmem_address, 16'h4002);
    cyc(); pmem_resp = 1'b1; pmem_rdata = 16'h4444;
    settle();
    check("ct_mem_resp2", {15'd0, mem_resp}, 16'd1);
    cyc(); pmem_resp = 1'b0; mem_read = 1'b0;

    // asynchronous reset in the middle of a fetch
    cyc(); ifetch_read = 1'b1; ifetch_address = 16'h0600;
    cyc(); settle();
    check("ar_pread_before", {15'd0, pmem_read}, 16'd1);
    #1 reset_n = 1'b0; pmem_resp = 1'b1;
    #1;
    check("ar_pread_drop", {15'd0, pmem_read}, 16'd0);
    check("ar_no_if_resp", {15'd0, ifetch_resp}, 16'd0);
    check("ar_state", {14'd0, dbg_state}, S_IDLE);
    check("ar_paddr_clr", pmem_address, 16'h0000);
    cyc(); reset_n = 1'b1; pmem_resp = 1'b0; ifetch_address = 16'h0700;
    cyc(); settle();
    check("ar_regrant", {15'd0, pmem_read}, 16'd1);
    check("ar_recapture", pmem_address, 16'h0700);
    cyc(); pmem_resp = 1'b1; pmem_rdata = 16'h3333;
    settle();
    check("ar_if_resp", {15'd0, ifetch_resp}, 16'd1);
    check("ar_if_rdata", ifetch_rdata, 16'h3333);
    cyc(); pmem_resp = 1'b0; ifetch_read = 1'b0;
    cyc();

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
